fp_to_int_piped: RTL and testbench

FP_TO_INT_PIPED -- requirements
Module: fp_to_int_piped

---
 rtl/fp_pkg.sv | 42 ++++
 rtl/fp2int_align.sv | 31 +++
 rtl/fp_to_int_piped.sv | 164 ++++++++++++++++
 tb/tb_fp_to_int_piped.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision float constants, operand class encoding and the
// classifier used by the float-to-integer converter.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] NEG_2_31 = 32'hCF00_0000;

  typedef enum logic [2:0] {
    ZERO_SMALL = 3'd0,
    NORMAL     = 3'd1,
    INF        = 3'd2,
    NAN        = 3'd3,
    OVF        = 3'd4
  } fp_class_e;

  // -2^31 is exactly representable, so it is routed through the normal path.
  function automatic fp_class_e fp_classify(input logic [31:0] f);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    fp_class_e        c;
    e = f[30:23];
    m = f[22:0];
    if (e == 8'hFF) begin
      if (m != 23'd0) c = NAN;
      else            c = INF;
    end else if (e < 8'(BIAS)) begin
      c = ZERO_SMALL;
    end else if (e >= 8'(BIAS + 31)) begin
      if (f == NEG_2_31) c = NORMAL;
      else               c = OVF;
    end else begin
      c = NORMAL;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp2int_align.sv
// Combinational barrel shifter aligning the 24-bit significand to an integer
// magnitude; sticky reports any one bit lost off the right end.
module fp2int_align
  import fp_pkg::*;
(
  input  logic        [MAN_W:0] sig,
  input  logic signed [5:0]     shamt,
  output logic        [31:0]    mag,
  output logic                  sticky
);

  logic [5:0]     amt;
  logic [MAN_W:0] mask;

  always_comb begin
    mag    = 32'd0;
    sticky = 1'b0;
    amt    = 6'd0;
    mask   = {(MAN_W+1){1'b0}};
    if (shamt[5] == 1'b0) begin
      amt = shamt;
      mag = {8'd0, sig} << amt;
    end else begin
      amt    = 6'(-shamt);
      mag    = {8'd0, (sig >> amt)};
      mask   = ~({(MAN_W+1){1'b1}} << amt);
      sticky = |(sig & mask);
    end
  end

endmodule

// File: rtl/fp_to_int_piped.sv
// Three-stage float-to-int32 converter, truncating toward zero:
// S1 unpack/classify, S2 align, S3 negate/saturate/flag.
module fp_to_int_piped
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        clear_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_nan,
  output logic        out_ovf,
  output logic        out_inexact
);

  logic               v1_d, v1_q, sign1_d, sign1_q, small_nz1_d, small_nz1_q;
  fp_class_e          cls1_d, cls1_q;
  logic [MAN_W:0]     sig1_d, sig1_q;
  logic signed [5:0]  shamt1_d, shamt1_q;

  logic               v2_d, v2_q, sign2_d, sign2_q, inx2_d, inx2_q;
  fp_class_e          cls2_d, cls2_q;
  logic [31:0]        mag2_d, mag2_q;

  logic               out_valid_d, out_valid_q, out_nan_d, out_nan_q;
  logic               out_ovf_d, out_ovf_q, out_inexact_d, out_inexact_q;
  logic [31:0]        out_data_d, out_data_q;

  logic [31:0]        align_mag;
  logic               align_sticky;

  fp2int_align u_align (
    .sig    (sig1_q),
    .shamt  (shamt1_q),
    .mag    (align_mag),
    .sticky (align_sticky)
  );

  // S1: unpack; shift amount is u-23, i.e. exponent-150, in the range -23..8.
  always_comb begin
    v1_d        = v1_q;
    sign1_d     = sign1_q;
    cls1_d      = cls1_q;
    sig1_d      = sig1_q;
    shamt1_d    = shamt1_q;
    small_nz1_d = small_nz1_q;
    if (!stall) begin
      v1_d        = in_valid;
      sign1_d     = in_data[31];
      cls1_d      = fp_classify(in_data);
      sig1_d      = {1'b1, in_data[MAN_W-1:0]};
      shamt1_d    = 6'(in_data[30:23] - 8'd150);
      small_nz1_d = |in_data[30:0];
    end else begin
      v1_d = v1_q;
    end
  end

  always_comb begin
    v2_d    = v2_q;
    sign2_d = sign2_q;
    cls2_d  = cls2_q;
    mag2_d  = mag2_q;
    inx2_d  = inx2_q;
    if (!stall) begin
      v2_d    = v1_q;
      sign2_d = sign1_q;
      cls2_d  = cls1_q;
      mag2_d  = align_mag;
      case (cls1_q)
        NORMAL:     inx2_d = align_sticky;
        ZERO_SMALL: inx2_d = small_nz1_q;
        default:    inx2_d = 1'b0;
      endcase
    end else begin
      v2_d = v2_q;
    end
  end

  // S3: bubbles leave all outputs at zero.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_nan_d     = out_nan_q;
    out_ovf_d     = out_ovf_q;
    out_inexact_d = out_inexact_q;
    if (!stall) begin
      out_valid_d   = v2_q;
      out_data_d    = 32'd0;
      out_nan_d     = 1'b0;
      out_ovf_d     = 1'b0;
      out_inexact_d = 1'b0;
      if (v2_q) begin
        case (cls2_q)
          NORMAL: begin
            out_data_d    = sign2_q ? (~mag2_q + 32'd1) : mag2_q;
            out_inexact_d = inx2_q;
          end
          ZERO_SMALL: out_inexact_d = inx2_q;
          INF, OVF: begin
            out_data_d = sign2_q ? INT_MIN : INT_MAX;
            out_ovf_d  = 1'b1;
          end
          NAN: begin
            out_data_d = INT_MIN;
            out_nan_d  = 1'b1;
          end
          default: out_data_d = 32'd0;
        endcase
      end else begin
        out_data_d = 32'd0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      v1_q          <= 1'b0;
      sign1_q       <= 1'b0;
      cls1_q        <= ZERO_SMALL;
      sig1_q        <= '0;
      shamt1_q      <= 6'sd0;
      small_nz1_q   <= 1'b0;
      v2_q          <= 1'b0;
      sign2_q       <= 1'b0;
      cls2_q        <= ZERO_SMALL;
      mag2_q        <= 32'd0;
      inx2_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 32'd0;
      out_nan_q     <= 1'b0;
      out_ovf_q     <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      v1_q          <= v1_d;
      sign1_q       <= sign1_d;
      cls1_q        <= cls1_d;
      sig1_q        <= sig1_d;
      shamt1_q      <= shamt1_d;
      small_nz1_q   <= small_nz1_d;
      v2_q          <= v2_d;
      sign2_q       <= sign2_d;
      cls2_q        <= cls2_d;
      mag2_q        <= mag2_d;
      inx2_q        <= inx2_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_nan_q     <= out_nan_d;
      out_ovf_q     <= out_ovf_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_nan     = out_nan_q;
  assign out_ovf     = out_ovf_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fp_to_int_piped.sv
// Bench for fp_to_int_piped: directed spec vectors, stall/reset scenarios and
// random traffic against an arithmetic reference model behind a 3-deep delay line.
module tb_fp_to_int_piped;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        nan;
    logic        ovf;
    logic        inx;
  } res_t;

  logic        clk = 1'b0;
  logic        clear_n, in_valid, stall;
  logic [31:0] in_data;
  logic        out_valid, out_nan, out_ovf, out_inexact;
  logic [31:0] out_data;

  int   checks   = 0;
  int   failures = 0;
  res_t pipe [3];

  fp_to_int_piped dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .stall       (stall),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_nan     (out_nan),
    .out_ovf     (out_ovf),
    .out_inexact (out_inexact)
  );

  always #5 clk = ~clk;

  // Value = 1.man * 2^(exp-127), truncated toward zero; out of int32 range saturates.
  function automatic res_t ref_conv(input logic [31:0] f);
    res_t    r;
    int      e, u;
    longint  sig, mag, sval, div;
    r       = '0;
    r.valid = 1'b1;
    e       = int'(f[30:23]);
    sig     = longint'({1'b1, f[22:0]});
    if (e == 255) begin
      if (f[22:0] != 23'd0) begin
        r.data = 32'h8000_0000;
        r.nan  = 1'b1;
      end else begin
        r.data = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        r.ovf  = 1'b1;
      end
    end else if (e < 127) begin
      r.inx = (f[30:0] != 31'd0);
    end else begin
      u = e - 127;
      if (u > 40) begin
        sval = f[31] ? -64'sd4294967296 : 64'sd4294967296;
      end else if (u >= 23) begin
        sval = sig * (64'sd1 <<< (u - 23));
        if (f[31]) sval = -sval;
      end else begin
        div   = 64'sd1 <<< (23 - u);
        mag   = sig / div;
        r.inx = (sig % div) != 64'sd0;
        sval  = f[31] ? -mag : mag;
      end
      if (sval > 64'sd2147483647 || sval < -64'sd2147483648) begin
        r.data = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        r.ovf  = 1'b1;
        r.inx  = 1'b0;
      end else begin
        r.data = sval[31:0];
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, advance the model, then compare every output with the model.
  task automatic step(input logic v, input logic [31:0] d, input logic st, input logic cl);
    in_valid = v;
    in_data  = d;
    stall    = st;
    clear_n  = cl;
    @(posedge clk);
    if (!cl) begin
      pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
    end else if (!st) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = v ? ref_conv(d) : '0;
    end
    #1;
    chk("valid",   {31'd0, out_valid},   {31'd0, pipe[2].valid});
    chk("data",    out_data,             pipe[2].data);
    chk("nan",     {31'd0, out_nan},     {31'd0, pipe[2].nan});
    chk("ovf",     {31'd0, out_ovf},     {31'd0, pipe[2].ovf});
    chk("inexact", {31'd0, out_inexact}, {31'd0, pipe[2].inx});
  endtask

  // Send one operand, wait out the latency, and check against fixed expectations.
  task automatic directed(input string tag, input logic [31:0] op, input logic [31:0] exp_data,
                          input logic exp_nan, input logic exp_ovf, input logic exp_inx);
    step(1'b1, op, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"},  out_data, exp_data);
    chk({tag, "_flags"}, {29'd0, out_nan, out_ovf, out_inexact}, {29'd0, exp_nan, exp_ovf, exp_inx});
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  e;
    pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;

    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'h3F80_0000, 1'b1, 1'b0);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_data",  out_data, 32'd0);

    directed("one",     32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    directed("m2p5",    32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    directed("half",    32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    directed("p2_31",   32'h4F00_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    directed("m2_31",   32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    directed("ninf",    32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed("pinf",    32'h7F80_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    directed("nan",     32'h7FC0_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    directed("negzero", 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    directed("denorm",  32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    directed("maxint",  32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 1'b0);

    // Stream 1.0, 2.0, stall two cycles, then 3.0.
    step(1'b1, 32'h3F80_0000, 1'b0, 1'b1);
    step(1'b1, 32'h4000_0000, 1'b0, 1'b1);
    step(1'b1, 32'h4120_0000, 1'b1, 1'b1);
    chk("stall_hold0", {31'd0, out_valid}, 32'd0);
    step(1'b1, 32'h4120_0000, 1'b1, 1'b1);
    chk("stall_hold1", {31'd0, out_valid}, 32'd0);
    step(1'b1, 32'h4040_0000, 1'b0, 1'b1);
    chk("stream_1", {31'd0, out_valid, out_data[0]} == 32'd0 ? 32'd0 : out_data, 32'd1);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("stream_2", out_data, 32'd2);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    chk("stream_2_frozen", out_data, 32'd2);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("stream_3", out_data, 32'd3);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("stream_end", {31'd0, out_valid}, 32'd0);

    // Reset with three operands in flight.
    step(1'b1, 32'h3F80_0000, 1'b0, 1'b1);
    step(1'b1, 32'h4000_0000, 1'b0, 1'b1);
    step(1'b1, 32'h4040_0000, 1'b0, 1'b1);
    step(1'b1, 32'h4080_0000, 1'b0, 1'b0);
    chk("midreset_all", {out_valid, out_nan, out_ovf, out_inexact, out_data[27:0]}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'd0, 1'b0, 1'b1);
      chk("no_stale", {31'd0, out_valid}, 32'd0);
    end

    // Random traffic, biased toward the interesting exponent range.
    for (int i = 0; i < 600; i++) begin
      d = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        e = 8'($urandom_range(118, 162));
        d[30:23] = e;
      end else if ($urandom_range(0, 3) == 0) begin
        d[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        if ($urandom_range(0, 1) != 0) d[22:0] = 23'd0;
      end
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 7) == 0, $urandom_range(0, 63) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
